// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared types and constants for the instruction-fetch slice.
//
// Contents:
//   INSTR_BYTES    byte stride between consecutive instructions
//   fetch_state_e  fetch controller state (FS_RUN, FS_FAULT)
//   fetch_entry_t  one queued {pc, instr} pair handed to decode
package fetch_pkg;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FS_RUN   = 1'b0,
        FS_FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue -- small synchronous FIFO of fetch_entry_t.
//
// Ports:
//   clk        in   core clock, rising edge
//   rst        in   asynchronous, active-high reset (empties the queue)
//   flush      in   synchronous flush; wins over push and pop
//   push       in   write push_data at the tail this edge
//   push_data  in   entry to write
//   pop        in   drop the head entry this edge
//   head       out  head entry, all zeros when the queue is empty
//   empty      out  no entries held
//   full       out  QUEUE_DEPTH entries held
//
// Push and pop may both be asserted on a full queue: the slot being vacated
// by the pop is the one the push writes, and the head read is combinational
// from the old contents, so the entry count stays unchanged.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    fetch_entry_t mem [QUEUE_DEPTH];

    // Extra MSB on each pointer tells a full queue from an empty one when
    // the index bits coincide.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // slots are meaningful, and the head output is masked when empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch initiator with a small decode-side queue.
//
// Ports:
//   clk             in   core clock, rising edge
//   rst             in   asynchronous, active-high reset
//   imem_addr       out  byte fetch address (always equal to fetch_pc)
//   imem_instr      in   instruction word at imem_addr, same cycle
//   redirect_valid  in   replace PC and flush the queue
//   redirect_pc     in   new fetch target, must be word aligned
//   out_valid       out  queue head valid
//   out_ready       in   decode accepts the head
//   out_pc          out  head PC (0 when nothing is held)
//   out_instr       out  head instruction (0 when nothing is held)
//   fault           out  sticky misaligned-redirect flag, cleared only by rst
//   perf_fetched    out  enqueued-instruction count
//   perf_stall      out  cycles stalled on a full queue
//
// Build option FETCH_PERF_EN: when defined, perf_fetched/perf_stall are live
// wrapping 32-bit counters; otherwise both outputs are tied to zero.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fault,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  fetch_pc;
    fetch_entry_t head;
    fetch_entry_t new_entry;
    logic         q_empty;
    logic         q_full;
    logic         deq;
    logic         enq;
    logic         redirect_hit;
    logic         misaligned;

    // Redirects only act while running; in FS_FAULT they are ignored.
    assign redirect_hit = (state_q == FS_RUN) && redirect_valid;
    assign misaligned   = (redirect_pc[1:0] != 2'b00);

    assign out_valid = (state_q == FS_RUN) && !q_empty;
    assign deq       = out_valid && out_ready;
    // A full queue can still accept when the head leaves in the same cycle.
    assign enq       = (state_q == FS_RUN) && !redirect_valid && (!q_full || deq);

    assign new_entry = '{pc: fetch_pc, instr: imem_instr};

    fetch_queue #(
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_hit),
        .push      (enq),
        .push_data (new_entry),
        .pop       (deq),
        .head      (head),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;
    assign imem_addr = fetch_pc;
    assign fault     = (state_q == FS_FAULT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FS_RUN;
        else     state_q <= state_d;
    end

    // Next-state logic: FS_FAULT is absorbing until reset.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = state_q;
        if (redirect_hit && misaligned) state_d = FS_FAULT;
    end

    // Sequential PC; a misaligned redirect leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             fetch_pc <= RESET_PC;
        else if (redirect_hit && !misaligned) fetch_pc <= redirect_pc;
        else if (enq)                         fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
    end

`ifdef FETCH_PERF_EN
    logic stall;

    assign stall = (state_q == FS_RUN) && q_full && !deq && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (enq)   perf_fetched <= perf_fetched + 32'd1;
            if (stall) perf_stall   <= perf_stall + 32'd1;
        end
    end
`else
    assign perf_fetched = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch initiator that drives the byte address into the combinational instruction memory and captures the returned word.
- Buffers fetched {pc, instr} pairs in a small queue and presents them to decode over a valid/ready handshake.
- Owns the sequential PC and accepts redirects from execute (branch/jump).
- Traps misaligned redirect targets into a sticky fault state.

Parameters:
- RESET_PC, 32'h0000_0000, first byte address fetched after reset.
- QUEUE_DEPTH, 2, fetch queue entries; power of two, ≥2.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte fetch address, equal to fetch_pc.
- imem_instr  in  32  instruction word at imem_addr, valid in the same cycle.
- redirect_valid  in  1  replace PC and flush queue.
- redirect_pc  in  32  new fetch target; must be word-aligned.
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  32  head PC.
- out_instr  out  32  head instruction.
- fault  out  1  sticky misaligned-redirect flag.
- perf_fetched  out  32  fetched-instruction count (optional feature).
- perf_stall  out  32  queue-full stall cycles (optional feature).

Behaviour:
- Reset (async assert):
  - fetch_pc=RESET_PC, queue empty, state FS_RUN.
  - out_valid=0, out_pc=0, out_instr=0, fault=0, perf counters=0.
- imem_addr = fetch_pc at all times, combinationally.
- deq = out_valid && out_ready.
- enq = state==FS_RUN && !redirect_valid && (count<QUEUE_DEPTH || deq).
  - When enq is high, {fetch_pc, imem_instr} is written at the edge and fetch_pc += 4.
  - Increment is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- Latency: an entry enqueued at edge N is visible as out_valid in the cycle after edge N. The first out_valid is the first cycle after reset deassert.
- Full queue with deq: enqueue and dequeue happen in the same cycle; count is unchanged.
- Full queue without deq: no enqueue, fetch_pc holds, perf_stall increments.
- out_pc/out_instr show the head entry, or 0 when the queue is empty.
- Redirect with redirect_pc[1:0]==0, at the edge:
  - queue flushed, fetch_pc=redirect_pc, no enqueue that cycle.
  - A deq occurring in the same cycle still counts as a completed transfer.
  - out_valid=0 in the following cycle.
  - The first new-target entry appears out_valid two cycles after the redirect cycle.
- Redirect with redirect_pc[1:0]!=0:
  - state goes to FS_FAULT, fault=1, queue flushed, fetch_pc holds its old value.
- FS_FAULT:
  - no enqueue, out_valid=0, further redirects ignored.
  - Exits only by rst.
- States: FS_RUN -> FS_FAULT on a misaligned redirect. No other transitions except reset.
- Reset mid-operation: all state clears immediately, including partially filled queue and fault.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - perf_fetched increments on every enq.
  - perf_stall increments on every cycle in FS_RUN with a full queue, no deq and no redirect.
  - Both counters wrap modulo 2^32 and clear on rst.
- Undefined: counter logic is not built; perf_fetched and perf_stall are tied to 0.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e {FS_RUN, FS_FAULT}.
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr}.
  - localparam INSTR_BYTES=4.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t, QUEUE_DEPTH entries.
  - Pointer wrap uses clog2(QUEUE_DEPTH) bits plus an extra bit for full/empty.
  - Synchronous flush input.
  - Simultaneous push/pop is allowed when full.

Test Plan:
- Stream: imem preloaded with instr=0xA000_0000|word_index, out_ready=1 from reset.
  - Expected: out_pc 0,4,8,... each cycle; out_instr matches; first out_valid one cycle after reset release.
- Backpressure: out_ready=0 for 5 cycles.
  - Expected: queue fills (2 entries), fetch_pc holds at 8, perf_stall=3 (with FETCH_PERF_EN); on release, PCs 0,4,8 arrive in order with no loss or duplication.
- Redirect: redirect_valid=1, redirect_pc=0x40 while head is pc=0x10 and out_ready=1.
  - Expected: 0x10 counted as accepted; out_valid=0 next cycle; next out_pc=0x40, then 0x44.
- Misaligned: redirect_pc=0x42.
  - Expected: fault=1 next cycle, out_valid stays 0 and later redirects are ignored; after rst, fault=0 and fetch restarts at RESET_PC.
- Wrap: redirect to 0xFFFF_FFF8 with a 2^32-word address model.
  - Expected: out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset mid-stream with a full queue.
  - Expected: out_valid drops to 0 without waiting for a clock edge; after release, out_pc=RESET_PC first.
